eeprom_word_fetch: RTL

//  Fetches one 32-bit instruction word from an external byte-wide parallel EEPROM (28C256-class).

---
 rtl/eeprom_word_fetch.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/eeprom_word_fetch.sv
// ----------------------------------------------------------------------------
// eeprom_word_fetch
//
// Fetches one 32-bit instruction word from a byte-wide parallel EEPROM
// (28C256-class). Each word costs four sequential byte reads. Every byte
// address is held for WAIT_CYCLES+1 clocks before its data is sampled. The
// four bytes are packed little-endian, so the byte at the lowest address
// lands in rsp_data[7:0].
//
// A request is rejected without touching the device when it is misaligned
// or when it lies at or above 2**ADDR_W. A rejected request returns
// rsp_err=1 and rsp_data=0.
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   word request handshake (req_ready high only in IDLE)
//   req_addr[31:0]        byte address of the requested word
//   rsp_valid/rsp_ready   response handshake
//   rsp_data[31:0]        assembled word, byte0 in [7:0] ... byte3 in [31:24]
//   rsp_err               request was rejected; rsp_data is zero
//   mem_addr[ADDR_W-1:0]  device byte address
//   mem_ce_n, mem_oe_n    device chip/output enable, active low
//   mem_data_in[7:0]      device data bus (read only)
//
// Parameters
//   ADDR_W       device byte-address width; must be less than 32
//   WAIT_CYCLES  extra cycles each byte address is held (device tACC), 0..15
// ----------------------------------------------------------------------------
module eeprom_word_fetch #(
   parameter int ADDR_W      = 15,
   parameter int WAIT_CYCLES = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_data,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_ce_n,
   output logic              mem_oe_n,
   input  logic [7:0]        mem_data_in
);

   localparam int CNT_W  = 4;
   localparam int BASE_W = ADDR_W - 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_e;

   state_e            state_q,     state_d;
   logic [BASE_W-1:0] base_q,      base_d;
   logic [1:0]        idx_q,       idx_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [31:0]       data_q,      data_d;
   logic              err_q,       err_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              req_ready_q, req_ready_d;
   logic              mem_en_n_q,  mem_en_n_d;

   logic              req_ok;

   // A word address is legal only when it is 4-byte aligned and fits the device.
   assign req_ok = (req_addr[1:0] == 2'b00) && (req_addr[31:ADDR_W] == '0);

   // Next-state logic.
   // NOTE: every _d gets a default from its _q before the case statement. No
   // path can leave a signal unassigned, so no latch can be inferred.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      req_ready_d = req_ready_q;
      mem_en_n_d  = mem_en_n_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               // Clear the data register on every accept. This keeps bytes
               // from an earlier word out of an error response.
               data_d      = '0;
               req_ready_d = 1'b0;
               if (!req_ok) begin
                  err_d       = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = ST_RESP;
               end else begin
                  err_d      = 1'b0;
                  base_d     = req_addr[ADDR_W-1:2];
                  idx_d      = 2'd0;
                  cnt_d      = CNT_W'(WAIT_CYCLES);
                  mem_en_n_d = 1'b0;
                  state_d    = ST_ACCESS;
               end
            end
         end

         ST_ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               // Capture edge: sample the device byte into its lane.
               // mem_addr advances only here.
               data_d[{idx_q, 3'b000} +: 8] = mem_data_in;
               if (idx_q == 2'd3) begin
                  mem_en_n_d  = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = ST_RESP;
               end else begin
                  idx_d = idx_q + 1'b1;
                  cnt_d = CNT_W'(WAIT_CYCLES);
               end
            end
         end

         ST_RESP: begin
            // req_ready rises only after the handshake edge. A new request can
            // therefore be accepted on the following edge at the earliest.
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            rsp_valid_d = 1'b0;
            req_ready_d = 1'b1;
            mem_en_n_d  = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   // NOTE: this block holds sequential state, so it uses only non-blocking
   // assignments. Every flop then updates from pre-edge values, whatever
   // order the simulator runs the processes in.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         data_q      <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         req_ready_q <= 1'b1;
         // The asynchronous reset releases CE#/OE# at once. A fetch that is
         // interrupted mid-word leaves the device bus immediately.
         mem_en_n_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         req_ready_q <= req_ready_d;
         mem_en_n_q  <= mem_en_n_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = data_q;
   assign rsp_err   = err_q;
   // The word base and byte index are concatenated, not added, so the
   // address cannot wrap inside a word.
   assign mem_addr  = {base_q, idx_q};
   // CE# and OE# always move together for a read-only device.
   assign mem_ce_n  = mem_en_n_q;
   assign mem_oe_n  = mem_en_n_q;

endmodule
